// File: rtl/sensor_ni_pkg.sv
// Purpose: shared constants for the sensor network-interface packetizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sensor_ni_pkg;

    // Flit type codes in the two MSBs of every flit
    localparam logic [1:0] FLIT_TYPE_HEAD = 2'b10;
    localparam logic [1:0] FLIT_TYPE_TAIL = 2'b01;
    localparam int         FLIT_TYPE_W    = 2;

    // Head flit fields, offsets counted down from the flit MSB
    localparam int HDR_DEST_W   = 4;
    localparam int HDR_SRC_W    = 4;
    localparam int HDR_IDX_W    = 8;
    localparam int HDR_DEST_OFS = FLIT_TYPE_W;
    localparam int HDR_SRC_OFS  = HDR_DEST_OFS + HDR_DEST_W;
    localparam int HDR_IDX_OFS  = HDR_SRC_OFS + HDR_SRC_W;

    // Packetizer FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

endpackage

// File: rtl/fixed_priority_encoder.sv
// Purpose: fixed-priority arbiter, bit 0 wins; one-hot grant, binary index, any flag.
// Latency: purely combinational.
// Backpressure: none.
module fixed_priority_encoder
    import sensor_ni_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [HDR_IDX_W-1:0] idx,
    output logic                 any
);

    // Scan from the top down so the lowest set bit is the last (winning) assignment
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = HDR_IDX_W'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/priority_sensor_packetizer.sv
// Purpose: grant one pending sensor interrupt, pulse its clear, inject a head+tail event packet.
// Latency: clear pulse and head flit one cycle after capture; tail follows head acceptance.
// Backpressure: flit_ready low holds the current flit stable; interrupts are not sampled until IDLE.
module priority_sensor_packetizer
    import sensor_ni_pkg::*;
#(
    parameter int         NUM_SENSORS = 4,
    parameter int         FLIT_W      = 32,
    parameter int         TS_W        = 16,
    parameter logic [3:0] LOCAL_ID    = 4'd0,
    parameter logic [3:0] DEST_ID     = 4'd0
) (
    input  logic                   clk,
    input  logic                   grst,
    input  logic [NUM_SENSORS-1:0] interrupt_in,
    output logic [NUM_SENSORS-1:0] clr_out,
    output logic [FLIT_W-1:0]      flit_out,
    output logic                   flit_valid,
    input  logic                   flit_ready,
    output logic                   busy
);

    state_t                 state_q, state_d;
    logic [TS_W-1:0]        ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0]        ts_q, ts_d;
    logic [HDR_IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_SENSORS-1:0] clr_q, clr_d;

    logic [NUM_SENSORS-1:0] enc_gnt;
    logic [HDR_IDX_W-1:0]   enc_idx;
    logic                   enc_any;

    fixed_priority_encoder #(
        .N (NUM_SENSORS)
    ) u_enc (
        .req (interrupt_in),
        .gnt (enc_gnt),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Next state: arbitrate only in IDLE, then walk head and tail through the ready handshake
    always_comb begin
        state_d  = state_q;
        ts_cnt_d = ts_cnt_q + TS_W'(1);
        ts_d     = ts_q;
        idx_d    = idx_q;
        clr_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    idx_d   = enc_idx;
                    ts_d    = ts_cnt_q;
                    clr_d   = enc_gnt;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (flit_ready) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (flit_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched fields; reset abandons any packet in flight
    always_ff @(posedge clk) begin
        if (grst) begin
            state_q  <= ST_IDLE;
            ts_cnt_q <= '0;
            ts_q     <= '0;
            idx_q    <= '0;
            clr_q    <= '0;
        end else begin
            state_q  <= state_d;
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
            idx_q    <= idx_d;
            clr_q    <= clr_d;
        end
    end

    // Flit mux decoded from registered state and latched fields only
    always_comb begin
        flit_out = '0;
        case (state_q)
            ST_HEAD: begin
                flit_out[FLIT_W-1 -: FLIT_TYPE_W]              = FLIT_TYPE_HEAD;
                flit_out[FLIT_W-1-HDR_DEST_OFS -: HDR_DEST_W]  = DEST_ID;
                flit_out[FLIT_W-1-HDR_SRC_OFS -: HDR_SRC_W]    = LOCAL_ID;
                flit_out[FLIT_W-1-HDR_IDX_OFS -: HDR_IDX_W]    = idx_q;
            end
            ST_TAIL: begin
                flit_out[FLIT_W-1 -: FLIT_TYPE_W] = FLIT_TYPE_TAIL;
                flit_out[TS_W-1:0]                = ts_q;
            end
            default: begin
                flit_out = '0;
            end
        endcase
    end

    assign clr_out    = clr_q;
    assign flit_valid = (state_q != ST_IDLE);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_priority_sensor_packetizer.sv
module tb_priority_sensor_packetizer;

    localparam logic [3:0] T_LOCAL = 4'h9;
    localparam logic [3:0] T_DEST  = 4'h5;

    logic        clk;
    logic        grst;
    logic [3:0]  interrupt_in;
    logic [3:0]  clr_out;
    logic [31:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] tb_cnt;
    logic [3:0]  clr_q[$];
    logic [31:0] flit_q[$];
    int          n_flits = 0;
    logic        drop_pend = 1'b0;
    int          drop_idx = 0;

    typedef struct {
        logic [3:0] irq;
        int         gap;
        int         hst;
        int         tst;
        int         idx;
    } vec_t;

    vec_t tbl[10];

    priority_sensor_packetizer #(
        .NUM_SENSORS (4),
        .FLIT_W      (32),
        .TS_W        (16),
        .LOCAL_ID    (T_LOCAL),
        .DEST_ID     (T_DEST)
    ) dut (
        .clk          (clk),
        .grst         (grst),
        .interrupt_in (interrupt_in),
        .clr_out      (clr_out),
        .flit_out     (flit_out),
        .flit_valid   (flit_valid),
        .flit_ready   (flit_ready),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference free-running timestamp
    always @(posedge clk) begin
        if (grst) tb_cnt <= '0;
        else      tb_cnt <= tb_cnt + 16'd1;
    end

    function automatic logic [31:0] head_flit(input logic [7:0] idx);
        return {2'b10, T_DEST, T_LOCAL, idx, 14'h0};
    endfunction

    function automatic logic [31:0] tail_flit(input logic [15:0] ts);
        return {2'b01, 14'h0, ts};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (drop_pend) begin
            interrupt_in[drop_idx] = 1'b0;
            drop_pend = 1'b0;
        end
    endtask

    // Scoreboard: every clear pulse and every accepted flit must match the next expectation
    always @(negedge clk) begin
        if (clr_out != 4'b0) begin
            if (clr_q.size() == 0) chk("clr_unexpected", {28'h0, clr_out}, 32'h0);
            else                   chk("clr_pulse", {28'h0, clr_out}, {28'h0, clr_q.pop_front()});
        end
        if (flit_valid === 1'b1 && flit_ready === 1'b1 && grst === 1'b0) begin
            n_flits++;
            if (flit_q.size() == 0) chk("flit_unexpected", flit_out, 32'h0);
            else                    chk("flit_accept", flit_out, flit_q.pop_front());
        end
    end

    task automatic run_event(input logic [3:0] irq, input int gap, input int hst,
                             input int tst, input int idx);
        logic [15:0] ts;
        logic [3:0]  oh;
        flit_ready = 1'b1;
        for (int i = 0; i < gap; i++) begin
            step();
            chk("idle_busy", {31'h0, busy}, 32'h0);
            chk("idle_valid", {31'h0, flit_valid}, 32'h0);
        end
        interrupt_in = interrupt_in | irq;
        ts = tb_cnt;
        oh = '0;
        oh[idx] = 1'b1;
        clr_q.push_back(oh);
        flit_q.push_back(head_flit(8'(idx)));
        flit_q.push_back(tail_flit(ts));
        step();
        chk("cap_clr", {28'h0, clr_out}, {28'h0, oh});
        chk("cap_busy", {31'h0, busy}, 32'h1);
        chk("head_flit", flit_out, head_flit(8'(idx)));
        drop_pend = 1'b1;
        drop_idx  = idx;
        flit_ready = (hst == 0);
        for (int i = 0; i < hst; i++) begin
            step();
            chk("head_hold", flit_out, head_flit(8'(idx)));
            chk("head_valid", {31'h0, flit_valid}, 32'h1);
            if (i == hst - 1) flit_ready = 1'b1;
        end
        step();
        chk("tail_flit", flit_out, tail_flit(ts));
        flit_ready = (tst == 0);
        for (int i = 0; i < tst; i++) begin
            step();
            chk("tail_hold", flit_out, tail_flit(ts));
            chk("tail_valid", {31'h0, flit_valid}, 32'h1);
            if (i == tst - 1) flit_ready = 1'b1;
        end
        step();
        chk("done_busy", {31'h0, busy}, 32'h0);
        chk("done_valid", {31'h0, flit_valid}, 32'h0);
        chk("done_flit", flit_out, 32'h0);
    endtask

    initial begin
        logic [15:0] ts;
        int          flits_before;

        // irq bits are OR-ed into whatever is still pending from earlier entries
        tbl[0] = '{4'b0000, 0, 0, 0, 0};
        tbl[1] = '{4'b0000, 0, 0, 0, 1};
        tbl[2] = '{4'b0000, 0, 4, 2, 2};
        tbl[3] = '{4'b0000, 0, 1, 1, 3};
        tbl[4] = '{4'b0100, 2, 0, 0, 2};
        tbl[5] = '{4'b1010, 1, 0, 0, 1};
        tbl[6] = '{4'b0000, 0, 0, 3, 3};
        tbl[7] = '{4'b1000, 0, 2, 0, 3};
        tbl[8] = '{4'b1001, 3, 0, 0, 0};
        tbl[9] = '{4'b0000, 0, 0, 0, 3};

        grst = 1'b1;
        interrupt_in = 4'b1111;
        flit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_clr", {28'h0, clr_out}, 32'h0);
            chk("rst_valid", {31'h0, flit_valid}, 32'h0);
            chk("rst_flit", flit_out, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
        end
        grst = 1'b0;

        // First entry captures the 1111 held through reset: index 0, timestamp 0
        for (int i = 0; i < 10; i++) begin
            flits_before = n_flits;
            run_event(tbl[i].irq, tbl[i].gap, tbl[i].hst, tbl[i].tst, tbl[i].idx);
            chk("flits_per_pkt", n_flits - flits_before, 32'd2);
        end

        // Reset while stalled in TAIL; the still-held interrupt is re-served afterwards
        interrupt_in = 4'b0100;
        flit_ready = 1'b1;
        ts = tb_cnt;
        clr_q.push_back(4'b0100);
        flit_q.push_back(head_flit(8'd2));
        step();
        chk("mr_clr", {28'h0, clr_out}, 32'h4);
        step();
        flit_ready = 1'b0;
        chk("mr_tail", flit_out, tail_flit(ts));
        step();
        chk("mr_tail_valid", {31'h0, flit_valid}, 32'h1);
        grst = 1'b1;
        step();
        chk("mr_valid", {31'h0, flit_valid}, 32'h0);
        chk("mr_busy", {31'h0, busy}, 32'h0);
        chk("mr_clr0", {28'h0, clr_out}, 32'h0);
        chk("mr_flit0", flit_out, 32'h0);
        grst = 1'b0;
        flit_ready = 1'b1;
        clr_q.push_back(4'b0100);
        flit_q.push_back(head_flit(8'd2));
        flit_q.push_back(tail_flit(16'h0000));
        step();
        chk("mr_reserve_clr", {28'h0, clr_out}, 32'h4);
        step();
        chk("mr_reserve_tail", flit_out, tail_flit(16'h0000));
        step();
        interrupt_in = 4'b0000;
        chk("mr_reserve_done", {31'h0, busy}, 32'h0);

        // Timestamp wrap: capture at FFFF, then the next packet shows the wrapped count
        for (int i = 0; i < 70000 && tb_cnt != 16'hFFFF; i++) step();
        run_event(4'b0001, 0, 0, 0, 0);
        run_event(4'b0100, 0, 0, 0, 2);
        step();

        chk("clr_q_empty", clr_q.size(), 32'h0);
        chk("flit_q_empty", flit_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/priority_sensor_packetizer.md
Name: priority_sensor_packetizer

Overview:
Consumes the level `interrupt` outputs of NUM_SENSORS priority sensor interfaces in a router's sensor network interface. It picks one pending interrupt by fixed priority and returns a one-cycle clear pulse to that interface's local `rst` input. It then injects a two-flit event packet (head + tail carrying a timestamp) into the router's local injection port through a valid/ready handshake.

Parameters:
NUM_SENSORS, 4, number of sensor interfaces served (1..16); index 0 is highest priority
FLIT_W, 32, flit width; must be >= 18 and >= TS_W+2
TS_W, 16, timestamp counter width
LOCAL_ID, 0, 4-bit node ID placed in the head flit as source
DEST_ID, 0, 4-bit node ID of the sensor sink placed in the head flit as destination

Ports:
clk  input  1  system clock, all logic on rising edge
grst  input  1  global reset, synchronous, active-high
interrupt_in  input  NUM_SENSORS  level interrupts from the sensor interfaces
clr_out  output  NUM_SENSORS  one-hot, one-cycle pulse to the granted interface's `rst`
flit_out  output  FLIT_W  flit to the router injection port
flit_valid  output  1  flit_out holds a valid flit
flit_ready  input  1  router accepts flit_out this cycle
busy  output  1  high whenever the state is not IDLE

Behaviour:
- One clock `clk`. Reset `grst` is synchronous and active-high, and is sampled only on the `clk` rising edge.
- Reset values: state=IDLE; clr_out=0; flit_valid=0; flit_out=0; busy=0; timestamp counter=0; latched sensor index=0; latched timestamp=0.
- Timestamp counter: free-running, +1 every cycle when grst=0, wraps from 2^TS_W-1 to 0.
- States: IDLE, HEAD, TAIL. All outputs are registered, or decoded from the registered state and latched fields only. No combinational path runs from interrupt_in or flit_ready to any output.
- IDLE: if interrupt_in != 0 at an edge:
  - grant the lowest set index g;
  - latch g and the counter value present before that edge's increment;
  - go to HEAD;
  - set clr_out to one-hot bit g for exactly the following cycle.
  If interrupt_in == 0, stay in IDLE.
- HEAD: flit_valid=1 and flit_out=head flit. On an edge with flit_ready=1, go to TAIL; otherwise hold, with flit_out stable.
- TAIL: flit_valid=1 and flit_out=tail flit. On an edge with flit_ready=1, go to IDLE; otherwise hold.
- interrupt_in is ignored in HEAD and TAIL. Arbitration happens only in IDLE, so the minimum event period is 3 cycles: capture, head, tail.
- Head flit fields:
  - [FLIT_W-1:FLIT_W-2] = 2'b10;
  - next 4 bits = DEST_ID;
  - next 4 bits = LOCAL_ID;
  - next 8 bits = sensor index, zero-extended;
  - all remaining bits = 0.
- Tail flit fields: [FLIT_W-1:FLIT_W-2] = 2'b01; [TS_W-1:0] = latched timestamp; all other bits = 0.
- Simultaneous interrupts: only the lowest index is granted. The other interfaces keep their interrupt asserted and are served in later packets in index order. Persistent low-index events can starve higher indices; this is accepted.
- Clear timing: the upstream interface drops its interrupt one edge after clr_out. Because of the HEAD/TAIL dwell, the already-served index is never re-granted from a stale level.
- flit_ready high in IDLE is ignored.
- grst mid-packet: on the next edge, state=IDLE, flit_valid=0 and clr_out=0, and the packet is abandoned. The router shares grst, so no tail is owed.
- grst has priority over every transition on the same edge.

Decomposition:
- Package sensor_ni_pkg holds:
  - the flit type codes (HEAD=2'b10, TAIL=2'b01);
  - the head field offsets and widths (dest, src, sensor index);
  - the state encoding constants (IDLE, HEAD, TAIL).
- Sub-module fixed_priority_encoder (parameter N) is natural. It takes a request vector and produces a one-hot grant, a binary index and an any-request flag.
- Everything else lives in the top level: FSM, timestamp counter, field latches and flit mux.

Test Plan:
- Reset: hold grst for 3 cycles with interrupt_in=4'b1111 -> all outputs 0, busy=0, counter reads 0 after release.
- Single event, ready tied high: interrupt_in[2] rises while the counter is at 5 -> next cycle:
  - clr_out=4'b0100 for 1 cycle;
  - head flit = {2'b10, DEST_ID, LOCAL_ID, 8'd2, 0s};
  - the following cycle, tail low bits = 16'd5;
  - IDLE after that.
- Back-pressure: flit_ready=0 for 4 cycles during HEAD and 2 during TAIL -> flit_out stable, flit_valid=1, no duplicate clr_out, exactly 2 flits accepted.
- Priority: interrupt_in=4'b1010 held, each interface modelled to drop its bit one edge after its clr pulse -> packets for index 1 then index 3, with clr_out pulses 4'b0010 then 4'b1000.
- Wrap: TS_W=16, event captured with the counter at 16'hFFFF -> tail low bits 16'hFFFF; counter reads 0 the next cycle.
- Mid-packet reset: grst asserted while in TAIL with flit_ready=0 -> next cycle flit_valid=0, busy=0; a pending interrupt is re-served from IDLE after grst falls.
